// File: rtl/lcd_pkg.sv
// Shared LCD definitions: line geometry, blank line constant and the
// display arbiter state encoding.
package lcd_pkg;

  localparam int LCD_LINE_W = 128;
  localparam int LCD_CHARS  = 16;

  localparam logic [LCD_LINE_W-1:0] LCD_BLANK_LINE = {LCD_CHARS{8'h20}};

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    HOLD
  } arb_state_t;

  // Width of a requester index; never narrower than one bit.
  function automatic int lcd_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lcd_rr_picker.sv
// Combinational round-robin picker: the first asserted request at or after
// the pointer (wrapping) wins.
module lcd_rr_picker
  import lcd_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0]            req,
  input  logic [lcd_idx_w(N_REQ)-1:0] pointer,
  output logic                        valid,
  output logic [lcd_idx_w(N_REQ)-1:0] winner
);

  localparam int W = lcd_idx_w(N_REQ);

  logic [W-1:0]     cand_idx [N_REQ];
  logic [N_REQ-1:0] cand_req;

  // Candidate gi is the requester gi positions after the pointer.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
    logic [W:0] sum;
    assign sum          = {1'b0, pointer} + (W+1)'(gi);
    assign cand_idx[gi] = (sum >= (W+1)'(N_REQ)) ? W'(sum - (W+1)'(N_REQ)) : W'(sum);
    assign cand_req[gi] = req[cand_idx[gi]];
  end

  assign valid = |cand_req;

  always_comb begin
    winner = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (cand_req[k]) winner = cand_idx[k];
    end
  end

endmodule

// File: rtl/lcd_display_arbiter.sv
// Round-robin sharing of one lcd_controller between several text producers,
// with a busy handshake and a minimum on-screen hold per granted message.
module lcd_display_arbiter
  import lcd_pkg::*;
#(
  parameter int          N_REQ        = 2,
  parameter int unsigned HOLD_CYCLES  = 100_000_000,
  parameter int unsigned BUSY_TIMEOUT = 16
) (
  input  logic                          clk,
  input  logic                          reset_btn,
  input  logic [N_REQ-1:0]              req,
  input  logic [N_REQ*LCD_LINE_W-1:0]   req_line1,
  input  logic [N_REQ*LCD_LINE_W-1:0]   req_line2,
  output logic [N_REQ-1:0]              ack,
  output logic [lcd_idx_w(N_REQ)-1:0]   grant_id,
  output logic                          busy,
  output logic [LCD_LINE_W-1:0]         line1,
  output logic [LCD_LINE_W-1:0]         line2,
  output logic                          refresh,
  input  logic                          ready
);

  localparam int W = lcd_idx_w(N_REQ);

  // Zero-length hold or timeout degenerates to a single cycle.
  localparam logic [31:0] HOLD_LAST = (HOLD_CYCLES  == 0) ? 32'd0 : 32'(HOLD_CYCLES - 1);
  localparam logic [31:0] BUSY_LAST = (BUSY_TIMEOUT == 0) ? 32'd0 : 32'(BUSY_TIMEOUT - 1);

  arb_state_t              state_reg, state_next;
  logic [W-1:0]            pointer_reg, pointer_next;
  logic [W-1:0]            grant_reg, grant_next;
  logic [LCD_LINE_W-1:0]   line1_reg, line1_next;
  logic [LCD_LINE_W-1:0]   line2_reg, line2_next;
  logic                    refresh_reg, refresh_next;
  logic [N_REQ-1:0]        ack_reg, ack_next;
  logic [31:0]             hold_cnt_reg, hold_cnt_next;
  logic [31:0]             wait_cnt_reg, wait_cnt_next;

  logic                    pick_valid;
  logic [W-1:0]            pick_winner;
  logic [LCD_LINE_W-1:0]   cand_line1 [N_REQ];
  logic [LCD_LINE_W-1:0]   cand_line2 [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign cand_line1[gi] = req_line1[gi*LCD_LINE_W +: LCD_LINE_W];
    assign cand_line2[gi] = req_line2[gi*LCD_LINE_W +: LCD_LINE_W];
  end

  lcd_rr_picker #(
    .N_REQ (N_REQ)
  ) u_picker (
    .req     (req),
    .pointer (pointer_reg),
    .valid   (pick_valid),
    .winner  (pick_winner)
  );

  // ISSUE-cycle outputs are computed on the IDLE->ISSUE edge so that they
  // are registered and visible in the ISSUE cycle itself.
  always_comb begin
    state_next    = state_reg;
    pointer_next  = pointer_reg;
    grant_next    = grant_reg;
    line1_next    = line1_reg;
    line2_next    = line2_reg;
    refresh_next  = 1'b0;
    ack_next      = '0;
    hold_cnt_next = hold_cnt_reg;
    wait_cnt_next = wait_cnt_reg;

    unique case (state_reg)
      IDLE: begin
        if (ready && pick_valid) begin
          state_next   = ISSUE;
          line1_next   = cand_line1[pick_winner];
          line2_next   = cand_line2[pick_winner];
          grant_next   = pick_winner;
          refresh_next = 1'b1;
          ack_next     = N_REQ'(1) << pick_winner;
          pointer_next = (pick_winner == W'(N_REQ - 1)) ? '0 : pick_winner + W'(1);
        end
      end
      ISSUE: begin
        state_next    = WAIT_BUSY;
        wait_cnt_next = '0;
      end
      WAIT_BUSY: begin
        if (!ready) begin
          state_next = WAIT_DONE;
        end else if (wait_cnt_reg >= BUSY_LAST) begin
          // Controller finished instantly or never saw the pulse.
          state_next    = HOLD;
          hold_cnt_next = '0;
        end else begin
          wait_cnt_next = wait_cnt_reg + 32'd1;
        end
      end
      WAIT_DONE: begin
        if (ready) begin
          state_next    = HOLD;
          hold_cnt_next = '0;
        end
      end
      HOLD: begin
        if (hold_cnt_reg >= HOLD_LAST) begin
          state_next = IDLE;
        end else begin
          hold_cnt_next = hold_cnt_reg + 32'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_btn) begin
      state_reg    <= IDLE;
      pointer_reg  <= '0;
      grant_reg    <= '0;
      line1_reg    <= LCD_BLANK_LINE;
      line2_reg    <= LCD_BLANK_LINE;
      refresh_reg  <= 1'b0;
      ack_reg      <= '0;
      hold_cnt_reg <= '0;
      wait_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      pointer_reg  <= pointer_next;
      grant_reg    <= grant_next;
      line1_reg    <= line1_next;
      line2_reg    <= line2_next;
      refresh_reg  <= refresh_next;
      ack_reg      <= ack_next;
      hold_cnt_reg <= hold_cnt_next;
      wait_cnt_reg <= wait_cnt_next;
    end
  end

  assign ack      = ack_reg;
  assign grant_id = grant_reg;
  assign busy     = (state_reg != IDLE);
  assign line1    = line1_reg;
  assign line2    = line2_reg;
  assign refresh  = refresh_reg;

endmodule

// File: doc/lcd_display_arbiter.md
# lcd_display_arbiter

Shares the single `lcd_controller` between several text producers (Morse decoder output, status/banner logic, etc.). Each requester presents two 16-character lines and a request flag. The arbiter grants requests round-robin, latches the granted lines into the controller's line buffers and pulses `refresh`. It then tracks the controller's `ready` handshake and enforces a minimum on-screen hold time before serving the next request. It sits between the application producers and `lcd_controller` in the LCD top level.

## Interface

Parameters:
- `N_REQ`, 2: number of requesters, 2..4.
- `HOLD_CYCLES`, 100_000_000: minimum cycles a granted message stays displayed (1 s at 100 MHz).
- `BUSY_TIMEOUT`, 16: cycles to wait for `ready` to fall after `refresh`.

Ports (clock and reset first):
- `clk`, in, 1: 100 MHz system clock.
- `reset_btn`, in, 1: reset, **synchronous, active-low**.
- `req`, in, N_REQ: per-requester request level, held until acked.
- `req_line1`, in, N_REQ*128: line 1 text per requester; requester i occupies bits [128*i+127 : 128*i]; leftmost char in MSBs.
- `req_line2`, in, N_REQ*128: line 2 text, same packing.
- `ack`, out, N_REQ: one-cycle pulse; the requester's lines have been latched.
- `grant_id`, out, max(1,$clog2(N_REQ)): index of last granted requester.
- `busy`, out, 1: high in any state other than IDLE.
- `line1`, out, 128: to `lcd_controller.line1`.
- `line2`, out, 128: to `lcd_controller.line2`.
- `refresh`, out, 1: one-cycle pulse to `lcd_controller.refresh`.
- `ready`, in, 1: from `lcd_controller.ready`.

## Operation

Reset (`reset_btn`=0 at a clk edge) applies the following:
- `line1`/`line2` = 16 × 0x20 (blank).
- `refresh`=0, `ack`=0, `grant_id`=0, `busy`=0.
- Round-robin pointer set so requester 0 has highest priority.
- State = IDLE.
- Hold counter = 0.

States:
- **IDLE**: if `ready`=1 and `|req`, pick the winner, then go to ISSUE. Otherwise stay.
- **ISSUE** (1 cycle):
  - Latch the winner's `req_line1`/`req_line2` into `line1`/`line2`.
  - Set `grant_id`.
  - Pulse `refresh` and `ack[winner]`.
  - Set the pointer to winner+1 (mod N_REQ).
  - Go to WAIT_BUSY.
- **WAIT_BUSY**:
  - `ready`=0 → WAIT_DONE.
  - If `BUSY_TIMEOUT` cycles elapse with `ready` still 1 → HOLD. This covers a controller that completed instantly or ignored the pulse.
- **WAIT_DONE**: `ready`=1 → HOLD, with the hold counter cleared.
- **HOLD**: count to `HOLD_CYCLES`-1, then go to IDLE.

Arbitration rules:
- Round-robin search starting at the pointer. The first asserted `req` wins.
- The winner is sampled in IDLE and fixed for ISSUE. A `req` dropped after selection still receives its ack.
- Requesters must hold `req` and stable line data until `ack`. A requester must not reassert `req` in the cycle its `ack` is high.
- A `req` dropped before selection is treated as withdrawn, with no ack.

Output buffers:
- `line1`/`line2` change only in ISSUE. They are stable throughout the controller's write.
- Exactly one bit of `ack` is high per grant. `ack` is never high outside ISSUE.

## Timing

- Request to refresh: with `req` rising in cycle t and IDLE with `ready`=1, ISSUE occurs at t+1. `refresh`, `ack`, `line1`/`line2` and `grant_id` are all registered and valid in cycle t+1.
- Minimum grant-to-grant spacing = 1 + (busy wait) + (controller write) + `HOLD_CYCLES` + 1 cycles.
- Hold counter is 32-bit. `HOLD_CYCLES`=0 is treated as 1.
- If `ready` is low in IDLE, requests wait with no timeout.
- Reset mid-operation takes effect on the next edge. `refresh` and `ack` go low immediately. The controller's in-flight write completes independently.

## Structure

- Shared package `lcd_pkg` holds:
  - `LCD_LINE_W`=128, `LCD_CHARS`=16.
  - `LCD_BLANK_LINE` (16 × 0x20).
  - The arbiter state enum (IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, HOLD).
- Sub-module `lcd_rr_picker`: combinational round-robin selection.
  - Inputs: `req`, `pointer`.
  - Outputs: `valid`, `winner` index.
  - Reused by any later LCD/UART sharing logic.

## Test plan

Bench conditions: `N_REQ`=2, `HOLD_CYCLES`=10, `BUSY_TIMEOUT`=4, with a controller model that drops `ready` for 20 cycles after `refresh`.

1. Reset released with no requests → `line1`=`line2`=16 spaces, `refresh`/`ack`/`busy`=0 for 50 cycles.
2. `req`=2'b01 with line1="Morse Translator" → next cycle `refresh`=1, `ack`=2'b01, `line1`="Morse Translator". `busy` is high for 1+1+20+10 cycles, then IDLE.
3. `req`=2'b11 held, with the pointer at its reset value → grants in the order 0, 1, 0, 1. Consecutive `refresh` pulses are ≥31 cycles apart. `grant_id` alternates.
4. Controller model never drops `ready` → WAIT_BUSY times out after 4 cycles, then HOLD 10 cycles, then IDLE. Only one `ack` is issued.
5. `reset_btn`=0 asserted during WAIT_DONE → next edge gives `busy`=0, `line1`/`line2` blank, `refresh`=0. After release, a pending `req`=2'b10 is served once `ready`=1.
